// File: rtl/sb_dmem_resp.sv
// ---------------------------------------------------------------------------
// sb_dmem_resp : system-bus data-memory responder
//
// Purpose:
//   Far end of the core's load/store port. Holds a word-addressed data array
//   behind a small posted-write (store) buffer. Stores are queued and drain
//   into the array on idle bus cycles. Loads return extended data
//   combinationally. hold_o stalls the core when it must wait.
//
// Optional feature:
//   SB_STORE_FWD_EN defined   -> loads overlay buffered store lanes and never
//                                stall.
//   SB_STORE_FWD_EN undefined -> a load that hits a buffered word stalls and
//                                forces head drains until no entry matches.
//
// Parameters:
//   DEPTH_WORDS : data array depth in 32-bit words
//   WB_DEPTH    : store buffer entries (>= 1)
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   mem_re_i     in   load request
//   mem_we_i     in   store request
//   addr_i       in   byte address
//   byte_mask_i  in   4'b0001 byte, 4'b0011 half, 4'b1111 word (unshifted)
//   un_sign_i    in   1 = zero-extend load, 0 = sign-extend
//   wdata_i      in   right-aligned store data
//   rdata_o      out  extended load data (combinational)
//   hold_o       out  stall request to core (combinational)
//   err_o        out  misaligned / illegal access (combinational)
// ---------------------------------------------------------------------------
module sb_dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WB_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  byte_mask_i,
  input  logic        un_sign_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        hold_o,
  output logic        err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);

  // Expand a 4-bit lane mask to a 32-bit byte-enable mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
    return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

  // Advance a buffer pointer with wrap at WB_DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(WB_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [31:0]      mem_r      [DEPTH_WORDS];
  logic [IDX_W-1:0] wb_idx_r   [WB_DEPTH];
  logic [31:0]      wb_data_r  [WB_DEPTH];
  logic [3:0]       wb_lanes_r [WB_DEPTH];
  logic [WB_DEPTH-1:0] wb_valid_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic [IDX_W-1:0] idx_s;
  logic [1:0]       off_s;
  logic [3:0]       lanes_s;
  logic             legal_s;
  logic             full_s;
  logic             load_ok_s;
  logic             store_ok_s;
  logic             match_s;
  logic [31:0]      src_word_s;
  logic [31:0]      shifted_s;
  logic [31:0]      ext_s;
  logic             push_s;
  logic             drain_s;
  logic             hold_s;
  logic             unused_addr_s;

  assign idx_s         = addr_i[IDX_W+1:2];
  assign off_s         = addr_i[1:0];
  assign lanes_s       = byte_mask_i << off_s;
  assign full_s        = (count_r == CNT_W'(WB_DEPTH));
  assign unused_addr_s = ^addr_i[31:IDX_W+2];

  // Access legality: size/alignment check, and load+store together is never legal.
  always_comb begin
    legal_s = 1'b0;
    case (byte_mask_i)
      4'b0001: legal_s = 1'b1;
      4'b0011: legal_s = (off_s[0] == 1'b0);
      4'b1111: legal_s = (off_s == 2'b00);
      default: legal_s = 1'b0;
    endcase
    if (mem_re_i && mem_we_i) begin
      legal_s = 1'b0;
    end else begin
      legal_s = legal_s;
    end
  end

  assign load_ok_s  = ~rst & mem_re_i & legal_s;
  assign store_ok_s = ~rst & mem_we_i & legal_s;

  // Walk the buffer oldest-to-newest so the newest lane for a byte wins the overlay.
  always_comb begin
    logic [PTR_W:0]   sum_v;
    logic [PTR_W-1:0] slot_v;
    src_word_s = mem_r[idx_s];
    match_s    = 1'b0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      sum_v = {1'b0, head_r} + (PTR_W + 1)'(k);
      if (sum_v >= (PTR_W + 1)'(WB_DEPTH)) begin
        sum_v = sum_v - (PTR_W + 1)'(WB_DEPTH);
      end else begin
        sum_v = sum_v;
      end
      slot_v = sum_v[PTR_W-1:0];
      if (wb_valid_r[slot_v] && (wb_idx_r[slot_v] == idx_s)) begin
`ifdef SB_STORE_FWD_EN
        src_word_s = (src_word_s & ~lane_mask(wb_lanes_r[slot_v])) |
                     (wb_data_r[slot_v] & lane_mask(wb_lanes_r[slot_v]));
`else
        match_s = 1'b1;
`endif
      end else begin
        src_word_s = src_word_s;
      end
    end
  end

  assign shifted_s = src_word_s >> {off_s, 3'b000};

  // Size-select and extend the aligned load data.
  always_comb begin
    ext_s = 32'h0000_0000;
    case (byte_mask_i)
      4'b0001: ext_s = un_sign_i ? {24'h00_0000, shifted_s[7:0]}
                                 : {{24{shifted_s[7]}}, shifted_s[7:0]};
      4'b0011: ext_s = un_sign_i ? {16'h0000, shifted_s[15:0]}
                                 : {{16{shifted_s[15]}}, shifted_s[15:0]};
      4'b1111: ext_s = shifted_s;
      default: ext_s = 32'h0000_0000;
    endcase
  end

  // A full buffer refuses the store; a non-forwarded load hit waits for the drain.
  assign hold_s  = (store_ok_s & full_s) | (load_ok_s & match_s);
  assign push_s  = store_ok_s & ~full_s;
  assign drain_s = ~rst & (count_r != {CNT_W{1'b0}}) &
                   ((~mem_re_i & ~mem_we_i) | hold_s);

  assign rdata_o = load_ok_s ? ext_s : 32'h0000_0000;
  assign hold_o  = hold_s;
  assign err_o   = ~rst & (mem_re_i | mem_we_i) & ~legal_s;

  // Data array: head entry's masked lanes written on drain; contents survive reset.
  always_ff @(posedge clk) begin
    if (drain_s) begin
      mem_r[wb_idx_r[head_r]] <= (mem_r[wb_idx_r[head_r]] & ~lane_mask(wb_lanes_r[head_r])) |
                                 (wb_data_r[head_r] & lane_mask(wb_lanes_r[head_r]));
    end
  end

  // Store buffer FIFO: push at tail, pop at head, occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      wb_valid_r <= {WB_DEPTH{1'b0}};
    end else begin
      if (drain_s) begin
        wb_valid_r[head_r] <= 1'b0;
        head_r             <= ptr_inc(head_r);
      end
      if (push_s) begin
        wb_idx_r[tail_r]   <= idx_s;
        wb_data_r[tail_r]  <= wdata_i << {off_s, 3'b000};
        wb_lanes_r[tail_r] <= lanes_s;
        wb_valid_r[tail_r] <= 1'b1;
        tail_r             <= ptr_inc(tail_r);
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_dmem_resp.sv
module tb_sb_dmem_resp;

  logic        clk;
  logic        rst;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [31:0] addr_i;
  logic [3:0]  byte_mask_i;
  logic        un_sign_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        hold_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  sb_dmem_resp #(.DEPTH_WORDS(1024), .WB_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
    .addr_i(addr_i), .byte_mask_i(byte_mask_i), .un_sign_i(un_sign_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .hold_o(hold_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic we, input logic [31:0] a,
                       input logic [3:0] m, input logic u, input logic [31:0] d);
    mem_re_i = re; mem_we_i = we; addr_i = a; byte_mask_i = m; un_sign_i = u; wdata_i = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
      step();
    end
  endtask

  // Put a word into the array through the bus and let it drain.
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, 4'b1111, 1'b0, d);
    step();
    idle(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 32'h0);
    step(); step();
    #2;
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected %h", rdata_o, 32'h0); end
    checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b expected 0", hold_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_o); end
    step();
    rst = 1'b0;
    idle(1);
    checks++; if (dut.count_r !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", dut.count_r); end
  endtask

  task automatic test_load_word();
    preload(32'h0, 32'h8899AABB);
    drive(1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 32'h0);
    #2;
    checks++; if (rdata_o !== 32'h8899AABB) begin errors++; $display("FAIL load_word: got %h expected 8899aabb", rdata_o); end
    checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL load_word_hold: got %b expected 0", hold_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL load_word_err: got %b expected 0", err_o); end
    step();
    idle(1);
  endtask

  task automatic test_byte_store_load();
    drive(1'b0, 1'b1, 32'h5, 4'b0001, 1'b0, 32'h000000F0);
    step();
    drive(1'b1, 1'b0, 32'h5, 4'b0001, 1'b0, 32'h0);
    #2;
`ifndef SB_STORE_FWD_EN
    checks++; if (hold_o !== 1'b1) begin errors++; $display("FAIL byte_hit_hold: got %b expected 1", hold_o); end
    step();
    #2;
`endif
    checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL byte_load_hold: got %b expected 0", hold_o); end
    checks++; if (rdata_o !== 32'hFFFFFFF0) begin errors++; $display("FAIL byte_signed: got %h expected fffffff0", rdata_o); end
    step();
    drive(1'b1, 1'b0, 32'h5, 4'b0001, 1'b1, 32'h0);
    #2;
    checks++; if (rdata_o !== 32'h000000F0) begin errors++; $display("FAIL byte_unsigned: got %h expected 000000f0", rdata_o); end
    checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL byte_unsigned_hold: got %b expected 0", hold_o); end
    step();
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v [3];
    exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 32'h10 + 32'(4 * i), 4'b1111, 1'b0, exp_v[i]);
      #2;
      checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL b2b_hold%0d: got %b expected 0", i, hold_o); end
      step();
    end
    drive(1'b0, 1'b1, 32'h18, 4'b1111, 1'b0, exp_v[2]);
    #2;
    checks++; if (hold_o !== 1'b1) begin errors++; $display("FAIL b2b_full_hold: got %b expected 1", hold_o); end
    step();
    #2;
    checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL b2b_retry_hold: got %b expected 0", hold_o); end
    step();
    idle(3);
    checks++; if (dut.count_r !== 2'd0) begin errors++; $display("FAIL b2b_drained: got %0d expected 0", dut.count_r); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h10 + 32'(4 * i), 4'b1111, 1'b0, 32'h0);
      #2;
      checks++; if (rdata_o !== exp_v[i] || hold_o !== 1'b0) begin errors++; $display("FAIL b2b_load%0d: got %h hold %b expected %h hold 0", i, rdata_o, hold_o, exp_v[i]); end
      step();
    end
    idle(1);
  endtask

  task automatic test_merge();
    preload(32'h20, 32'h12345678);
    drive(1'b0, 1'b1, 32'h22, 4'b0011, 1'b0, 32'h0000BEEF);
    step();
    drive(1'b0, 1'b1, 32'h23, 4'b0001, 1'b0, 32'h00000001);
    step();
    idle(3);
    drive(1'b1, 1'b0, 32'h20, 4'b1111, 1'b0, 32'h0);
    #2;
    checks++; if (rdata_o !== 32'h01EF5678) begin errors++; $display("FAIL merge_word: got %h expected 01ef5678", rdata_o); end
    step();
    drive(1'b1, 1'b0, 32'h22, 4'b0011, 1'b0, 32'h0);
    #2;
    checks++; if (rdata_o !== 32'h000001EF) begin errors++; $display("FAIL merge_half: got %h expected 000001ef", rdata_o); end
    step();
    drive(1'b1, 1'b0, 32'h20, 4'b0011, 1'b0, 32'h0);
    #2;
    checks++; if (rdata_o !== 32'h00005678) begin errors++; $display("FAIL merge_low_half: got %h expected 00005678", rdata_o); end
    step();
    idle(1);
  endtask

  task automatic test_illegal();
    drive(1'b0, 1'b1, 32'h30, 4'b1111, 1'b0, 32'hA5A5A5A5);
    step();
    drive(1'b1, 1'b0, 32'h3, 4'b0011, 1'b0, 32'h0);
    #2;
    checks++; if (err_o !== 1'b1 || rdata_o !== 32'h0) begin errors++; $display("FAIL ill_half: got err %b data %h expected err 1 data 0", err_o, rdata_o); end
    step();
    drive(1'b0, 1'b1, 32'h6, 4'b1111, 1'b0, 32'hDEADBEEF);
    #2;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ill_word_store: got %b expected 1", err_o); end
    step();
    drive(1'b1, 1'b1, 32'h8, 4'b1111, 1'b0, 32'hDEADBEEF);
    #2;
    checks++; if (err_o !== 1'b1 || rdata_o !== 32'h0) begin errors++; $display("FAIL ill_re_we: got err %b data %h expected err 1 data 0", err_o, rdata_o); end
    step();
    drive(1'b1, 1'b0, 32'h8, 4'b0111, 1'b0, 32'h0);
    #2;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ill_mask: got %b expected 1", err_o); end
    step();
    checks++; if (dut.count_r !== 2'd1) begin errors++; $display("FAIL ill_count: got %0d expected 1", dut.count_r); end
    idle(3);
    drive(1'b1, 1'b0, 32'h4, 4'b1111, 1'b0, 32'h0);
    #2;
    checks++; if (rdata_o[15:8] !== 8'hF0) begin errors++; $display("FAIL ill_no_write: got %h expected f0", rdata_o[15:8]); end
    step();
    idle(1);
  endtask

  task automatic test_reset_mid();
    preload(32'h40, 32'hCAFEBABE);
    preload(32'h44, 32'h0BADF00D);
    drive(1'b0, 1'b1, 32'h40, 4'b1111, 1'b0, 32'h11111111);
    step();
    drive(1'b0, 1'b1, 32'h44, 4'b1111, 1'b0, 32'h22222222);
    step();
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h48, 4'b1111, 1'b0, 32'h33333333);
    #2;
    checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL rstmid_hold: got %b expected 0", hold_o); end
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    #2;
    checks++; if (dut.count_r !== 2'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", dut.count_r); end
    step();
    drive(1'b1, 1'b0, 32'h40, 4'b1111, 1'b0, 32'h0);
    #2;
    checks++; if (rdata_o !== 32'hCAFEBABE || hold_o !== 1'b0) begin errors++; $display("FAIL rstmid_load40: got %h hold %b expected cafebabe hold 0", rdata_o, hold_o); end
    step();
    drive(1'b1, 1'b0, 32'h44, 4'b1111, 1'b0, 32'h0);
    #2;
    checks++; if (rdata_o !== 32'h0BADF00D || hold_o !== 1'b0) begin errors++; $display("FAIL rstmid_load44: got %h hold %b expected 0badf00d hold 0", rdata_o, hold_o); end
    step();
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0);
    test_reset();
    test_load_word();
    test_byte_store_load();
    test_back_to_back();
    test_merge();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
